// File: rtl/vram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter_if
// Brief    : Display, CPU and VRAM-macro signal bundle for vram_arbiter.
// Revision : 1.0
// ============================================================================
interface vram_arbiter_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 16
);
  logic                  disp_req;
  logic [ADDR_W-1:0]     disp_addr;
  logic                  disp_gnt;
  logic                  disp_rvalid;
  logic [DATA_W-1:0]     disp_rdata;

  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_W-1:0]     cpu_addr;
  logic [DATA_W-1:0]     cpu_wdata;
  logic                  cpu_gnt;
  logic                  cpu_rvalid;
  logic [DATA_W-1:0]     cpu_rdata;
  logic                  cpu_err;

  logic                  mem_en;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output disp_req, disp_addr,
    input  disp_gnt, disp_rvalid, disp_rdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  disp_req, disp_addr,
    output disp_gnt, disp_rvalid, disp_rdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Brief    : Single-port VRAM sharing between display scan-out and CPU.
// Revision : 1.0
// ============================================================================
module vram_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 16,
  parameter int MAX_WAIT   = 4
) (
  input  wire logic     clk,
  input  wire logic     reset,
  vram_arbiter_if.slave bus
);
  localparam int c_WAIT_W = ($clog2(MAX_WAIT + 1) < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [c_WAIT_W-1:0] c_MAX_WAIT = c_WAIT_W'(MAX_WAIT);

  typedef enum logic [2:0] {
    K_NONE    = 3'd0,
    K_DISP_RD = 3'd1,
    K_CPU_RD  = 3'd2,
    K_CPU_WR  = 3'd3,
    K_ERR_RD  = 3'd4,
    K_ERR_WR  = 3'd5
  } kind_t;

  logic [c_WAIT_W-1:0]   r_wait_cnt, w_wait_nxt;
  logic                  w_cpu_gnt, w_disp_gnt, w_cpu_oor, w_cpu_issue;
  kind_t                 r_kind1, r_kind2, w_kind1_nxt;
  logic                  r_mem_en, r_mem_we;
  logic [DEPTH_LOG2-1:0] r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic [DATA_W-1:0]     r_disp_rdata, r_cpu_rdata, w_disp_rdata, w_cpu_rdata;

  generate
    if (ADDR_W > DEPTH_LOG2) begin : g_oor
      logic w_unused_disp_hi;
      assign w_cpu_oor        = |bus.cpu_addr[ADDR_W-1:DEPTH_LOG2];
      assign w_unused_disp_hi = ^bus.disp_addr[ADDR_W-1:DEPTH_LOG2];
    end else begin : g_no_oor
      assign w_cpu_oor = 1'b0;
    end
  endgenerate

  always_comb begin
    w_cpu_gnt  = 1'b0;
    w_disp_gnt = 1'b0;
    if (!reset) begin
      w_cpu_gnt  = bus.cpu_req && (!bus.disp_req || (r_wait_cnt == c_MAX_WAIT));
      w_disp_gnt = bus.disp_req && !w_cpu_gnt;
    end
  end

  assign w_cpu_issue = w_cpu_gnt && !w_cpu_oor;

  always_comb begin
    w_wait_nxt = '0;
    if (bus.cpu_req && !w_cpu_gnt)
      w_wait_nxt = (r_wait_cnt == c_MAX_WAIT) ? r_wait_cnt : r_wait_cnt + 1'b1;
  end

  always_comb begin
    w_kind1_nxt = K_NONE;
    if (w_cpu_gnt) begin
      case ({w_cpu_oor, bus.cpu_we})
        2'b00:   w_kind1_nxt = K_CPU_RD;
        2'b01:   w_kind1_nxt = K_CPU_WR;
        2'b10:   w_kind1_nxt = K_ERR_RD;
        default: w_kind1_nxt = K_ERR_WR;
      endcase
    end else if (w_disp_gnt) begin
      w_kind1_nxt = K_DISP_RD;
    end
  end

  // Return data comes straight from the macro in its valid cycle, then is held.
  always_comb begin
    w_disp_rdata = r_disp_rdata;
    w_cpu_rdata  = r_cpu_rdata;
    if (r_kind2 == K_DISP_RD) w_disp_rdata = bus.mem_rdata;
    if (r_kind2 == K_CPU_RD)  w_cpu_rdata  = bus.mem_rdata;
    if (r_kind2 == K_ERR_RD)  w_cpu_rdata  = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt   <= '0;
      r_kind1      <= K_NONE;
      r_kind2      <= K_NONE;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_disp_rdata <= '0;
      r_cpu_rdata  <= '0;
    end else begin
      r_wait_cnt   <= w_wait_nxt;
      r_kind1      <= w_kind1_nxt;
      r_kind2      <= r_kind1;
      r_mem_en     <= w_disp_gnt || w_cpu_issue;
      r_mem_we     <= w_cpu_issue && bus.cpu_we;
      if (w_disp_gnt)
        r_mem_addr <= bus.disp_addr[DEPTH_LOG2-1:0];
      else if (w_cpu_issue)
        r_mem_addr <= bus.cpu_addr[DEPTH_LOG2-1:0];
      if (w_cpu_issue && bus.cpu_we)
        r_mem_wdata <= bus.cpu_wdata;
      r_disp_rdata <= w_disp_rdata;
      r_cpu_rdata  <= w_cpu_rdata;
    end
  end

  assign bus.disp_gnt    = w_disp_gnt;
  assign bus.cpu_gnt     = w_cpu_gnt;
  assign bus.disp_rvalid = (r_kind2 == K_DISP_RD);
  assign bus.disp_rdata  = w_disp_rdata;
  assign bus.cpu_rvalid  = (r_kind2 == K_CPU_RD) || (r_kind2 == K_ERR_RD);
  assign bus.cpu_rdata   = w_cpu_rdata;
  assign bus.cpu_err     = (r_kind2 == K_ERR_RD) || (r_kind2 == K_ERR_WR);
  assign bus.mem_en      = r_mem_en;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_arbiter
// Brief    : Scoreboard bench for vram_arbiter with a behavioural VRAM model.
// Revision : 1.0
// ============================================================================
module tb_vram_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 8;
  localparam int DEPTH_LOG2 = 16;
  localparam int MAX_WAIT   = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  typedef struct packed {
    int         due;
    logic       rv;
    logic       err;
    logic [7:0] data;
  } ret_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) bus();

  vram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .MAX_WAIT(MAX_WAIT)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] vram    [DEPTH];
  logic [7:0] ref_mem [DEPTH];
  ret_t       disp_q[$];
  ret_t       cpu_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write-first synchronous VRAM macro
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        vram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata      <= bus.mem_wdata;
      end else begin
        bus.mem_rdata      <= vram[bus.mem_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: arbitration rule, wait count and a shadow memory updated in grant order
  int          m_wait = 0;
  logic        m_dgnt = 1'b0, m_cgnt = 1'b0;
  logic        x_en = 1'b0, x_we = 1'b0;
  logic [15:0] x_addr = '0;
  logic [7:0]  x_wdata = '0;
  logic        eg_c, eg_d;
  ret_t        r_m;

  always @(negedge clk) begin
    if (reset) begin
      m_wait = 0;
      disp_q.delete();
      cpu_q.delete();
      x_en   = 1'b0;
      m_dgnt = 1'b0;
      m_cgnt = 1'b0;
    end else begin
      chk("mem_en", 32'(bus.mem_en), 32'(x_en));
      if (x_en) begin
        chk("mem_we", 32'(bus.mem_we), 32'(x_we));
        chk("mem_addr", 32'(bus.mem_addr), 32'(x_addr));
        if (x_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(x_wdata));
      end
      eg_c = bus.cpu_req && (!bus.disp_req || m_wait >= MAX_WAIT);
      eg_d = bus.disp_req && !eg_c;
      chk("cpu_gnt", 32'(bus.cpu_gnt), 32'(eg_c));
      chk("disp_gnt", 32'(bus.disp_gnt), 32'(eg_d));
      m_wait = (bus.cpu_req && !eg_c) ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
      x_en = 1'b0;
      x_we = 1'b0;
      if (eg_d) begin
        x_en   = 1'b1;
        x_addr = bus.disp_addr[15:0];
        r_m    = '{due: cyc + 2, rv: 1'b1, err: 1'b0, data: ref_mem[x_addr]};
        disp_q.push_back(r_m);
      end
      if (eg_c) begin
        if (bus.cpu_addr >= 32'(DEPTH)) begin
          r_m = '{due: cyc + 2, rv: !bus.cpu_we, err: 1'b1, data: 8'h00};
          cpu_q.push_back(r_m);
        end else begin
          x_en   = 1'b1;
          x_addr = bus.cpu_addr[15:0];
          if (bus.cpu_we) begin
            x_we            = 1'b1;
            x_wdata         = bus.cpu_wdata;
            ref_mem[x_addr] = bus.cpu_wdata;
          end else begin
            r_m = '{due: cyc + 2, rv: 1'b1, err: 1'b0, data: ref_mem[x_addr]};
            cpu_q.push_back(r_m);
          end
        end
      end
      m_dgnt = eg_d;
      m_cgnt = eg_c;
    end
  end

  ret_t r_d, r_c;
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_ctrl", 32'({bus.disp_gnt, bus.disp_rvalid, bus.cpu_gnt, bus.cpu_rvalid,
                           bus.cpu_err, bus.mem_en, bus.mem_we}), 32'h0);
      chk("rst_rdata", 32'({bus.disp_rdata, bus.cpu_rdata}), 32'h0);
      chk("rst_mem", 32'({bus.mem_addr, bus.mem_wdata}), 32'h0);
    end else begin
      if (disp_q.size() > 0 && disp_q[0].due == cyc) begin
        r_d = disp_q.pop_front();
        chk("disp_rvalid", 32'(bus.disp_rvalid), 32'h1);
        chk("disp_rdata", 32'(bus.disp_rdata), 32'(r_d.data));
      end else begin
        chk("disp_rvalid_idle", 32'(bus.disp_rvalid), 32'h0);
      end
      if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
        r_c = cpu_q.pop_front();
        chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(r_c.rv));
        chk("cpu_err", 32'(bus.cpu_err), 32'(r_c.err));
        if (r_c.rv) chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(r_c.data));
      end else begin
        chk("cpu_idle", 32'({bus.cpu_rvalid, bus.cpu_err}), 32'h0);
      end
    end
  end

  task automatic drive(input logic dr, input logic [31:0] da, input logic cr, input logic cw,
                       input logic [31:0] ca, input logic [7:0] cd);
    @(posedge clk);
    #1;
    bus.disp_req  = dr;
    bus.disp_addr = da;
    bus.cpu_req   = cr;
    bus.cpu_we    = cw;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cd;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 8'h00);
  endtask

  function automatic logic [31:0] rand_addr(input logic is_cpu);
    logic [31:0] a;
    a = 32'($urandom_range(31));
    if (is_cpu && $urandom_range(7) == 0) a = 32'h0001_0000 + a;
    if (!is_cpu && $urandom_range(3) == 0) a = $urandom;
    return a;
  endfunction

  // Requests are held until the reference model reports them granted
  task automatic run_random(input int n, input int p_d, input int p_c);
    logic dr = 1'b0, cr = 1'b0, cw = 1'b0;
    logic [31:0] da = '0, ca = '0;
    logic [7:0] cd = '0;
    repeat (n) begin
      if (!dr || m_dgnt) begin
        dr = ($urandom_range(99) < p_d);
        da = rand_addr(1'b0);
      end
      if (!cr || m_cgnt) begin
        cr = ($urandom_range(99) < p_c);
        cw = 1'($urandom_range(1));
        ca = rand_addr(1'b1);
        cd = 8'($urandom);
      end
      drive(dr, da, cr, cw, ca, cd);
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      vram[i]    = 8'(i) ^ 8'hA5;
      ref_mem[i] = 8'(i) ^ 8'hA5;
    end
    bus.disp_req  = 1'b0;
    bus.disp_addr = '0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 4; i++) drive(1'b1, 32'(i), 1'b0, 1'b0, 32'h0, 8'h00);
    idle(3);

    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'd100, 8'h3C);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'd100, 8'h00);
    idle(4);

    run_random(25, 100, 100);
    idle(3);

    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0001_0000, 8'h00);
    idle(1);
    drive(1'b1, 32'h0001_0000, 1'b0, 1'b0, 32'h0, 8'h00);
    idle(3);

    drive(1'b1, 32'd7, 1'b0, 1'b0, 32'h0, 8'h00);
    @(posedge clk);
    #1;
    reset        = 1'b1;
    bus.disp_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(3);
    drive(1'b1, 32'd8, 1'b0, 1'b0, 32'h0, 8'h00);
    idle(3);

    run_random(3000, 60, 50);
    idle(5);
    @(negedge clk);
    #1;
    chk("disp_q_drained", 32'(disp_q.size()), 32'h0);
    chk("cpu_q_drained", 32'(cpu_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
